cordic_mac_accumulator: RTL and testbench

- Downstream stage of cordic_multiplier_approx_2UY that turns the single-shot approximate multiplier into a streaming dot-product engine.
- Accepts a stream of signed 8-bit operand pairs over valid/ready and issues each pair to the multiplier via start/done.
- Sign-extends and accumulates the 16-bit products.
- Presents the sum on an output valid/ready port when the vector ends (in_last) or reaches MAX_LEN.

---
 rtl/cordic_mac_accumulator.sv | 171 +++++++++++++++++
 tb/tb_cordic_mac_accumulator.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_mac_accumulator.sv
// cordic_mac_accumulator: streaming dot-product stage behind the approximate CORDIC
// multiplier. It takes signed 8-bit operand pairs over valid/ready and issues each pair
// to the multiplier with a start/done handshake. It sign-extends and sums the 16-bit
// products, then presents the sum when the vector ends on in_last or reaches MAX_LEN.
//
// Build option: define CORDIC_ACC_SAT_EN to turn on saturating accumulation. This also
// adds a sticky acc_sat output. Without it, the accumulator wraps modulo 2^ACC_W.
module cordic_mac_accumulator #(
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned MAX_LEN = 256,
    localparam int unsigned CntW   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_x,
    input  logic [7:0]         in_z,
    input  logic               in_last,
    output logic               mul_start,
    output logic [7:0]         mul_x,
    output logic [7:0]         mul_z,
    input  logic [15:0]        mul_y,
    input  logic               mul_done,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic [CntW-1:0]    acc_count,
`ifdef CORDIC_ACC_SAT_EN
    output logic               acc_sat,
`endif
    output logic               acc_len_err
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StGap, StOut} state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        z_q, z_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]  acc_wrap;
    logic [ACC_W-1:0]  acc_sum;
`ifdef CORDIC_ACC_SAT_EN
    logic              sat_q, sat_d;
    logic              ovf;
`endif

    // Next accumulator value: sign-extend the product, then wrap or clamp on overflow.
    always_comb begin
        prod_ext = ACC_W'($signed(mul_y));
        acc_wrap = acc_q + prod_ext;
`ifdef CORDIC_ACC_SAT_EN
        // Signed overflow happens only when both addends share a sign that the sum lost.
        ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_wrap[ACC_W-1] != acc_q[ACC_W-1]);
        if (ovf) begin
            acc_sum = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_sum = acc_wrap;
        end
`else
        acc_sum = acc_wrap;
`endif
    end

    // FSM next-state and datapath updates; a single pair is in flight at any time.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        z_d     = z_q;
        last_d  = last_q;
        err_d   = err_q;
`ifdef CORDIC_ACC_SAT_EN
        sat_d   = sat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    x_d     = in_x;
                    z_d     = in_z;
                    last_d  = in_last;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (mul_done) begin
                    acc_d   = acc_sum;
                    cnt_d   = cnt_q + 1'b1;
`ifdef CORDIC_ACC_SAT_EN
                    sat_d   = sat_q | ovf;
`endif
                    state_d = StGap;
                end
            end
            StGap: begin
                // The multiplier may hold done high, so wait for it to drop.
                if (!mul_done) begin
                    if (last_q || (cnt_q == MaxCnt)) begin
                        err_d   = !last_q;
                        state_d = StOut;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StOut: begin
                if (acc_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef CORDIC_ACC_SAT_EN
                    sat_d   = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset drops any product still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            z_q     <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CORDIC_ACC_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            z_q     <= z_d;
            last_q  <= last_d;
            err_q   <= err_d;
`ifdef CORDIC_ACC_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Output decode from state and registers.
    always_comb begin
        in_ready    = (state_q == StIdle) && !rst;
        mul_start   = (state_q == StIssue);
        mul_x       = x_q;
        mul_z       = z_q;
        acc_valid   = (state_q == StOut);
        acc_out     = acc_q;
        acc_count   = cnt_q;
        acc_len_err = err_q;
`ifdef CORDIC_ACC_SAT_EN
        acc_sat     = sat_q;
`endif
    end

endmodule

// File: tb/tb_cordic_mac_accumulator.sv
// Testbench for cordic_mac_accumulator: directed vectors with hand-computed sums.
// It honours CORDIC_ACC_SAT_EN to select the saturating or wrapping expectations.
module tb_cordic_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_z = '0;
    logic        in_last = 1'b0;
    logic        mul_start;
    logic [7:0]  mul_x;
    logic [7:0]  mul_z;
    logic [15:0] mul_y = '0;
    logic        mul_done = 1'b0;
    logic        acc_valid;
    logic        acc_ready = 1'b0;
    logic [23:0] acc_out;
    logic [8:0]  acc_count;
    logic        acc_len_err;
    logic        acc_sat;

    // Second instance, ACC_W=16, with a procedurally driven multiplier.
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic [7:0]  d_x = '0;
    logic [7:0]  d_z = '0;
    logic        d_last = 1'b0;
    logic        d_start;
    logic [7:0]  d_mx;
    logic [7:0]  d_mz;
    logic [15:0] d_my = '0;
    logic        d_done = 1'b0;
    logic        d_avalid;
    logic        d_aready = 1'b0;
    logic [15:0] d_out;
    logic [8:0]  d_count;
    logic        d_err;
    logic        d_sat;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural multiplier model state.
    int                 lat = 1;
    int                 cd = 0;
    int                 hold = 0;
    int                 start_cnt = 0;
    logic signed [15:0] prod = '0;

    always #5 clk = ~clk;

    cordic_mac_accumulator #(.ACC_W(24), .MAX_LEN(256)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_z(in_z), .in_last(in_last), .mul_start(mul_start), .mul_x(mul_x),
        .mul_z(mul_z), .mul_y(mul_y), .mul_done(mul_done), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .acc_out(acc_out), .acc_count(acc_count),
`ifdef CORDIC_ACC_SAT_EN
        .acc_sat(acc_sat),
`endif
        .acc_len_err(acc_len_err)
    );

    cordic_mac_accumulator #(.ACC_W(16), .MAX_LEN(256)) dut16 (
        .clk(clk), .rst(rst), .in_valid(d_valid), .in_ready(d_ready), .in_x(d_x),
        .in_z(d_z), .in_last(d_last), .mul_start(d_start), .mul_x(d_mx),
        .mul_z(d_mz), .mul_y(d_my), .mul_done(d_done), .acc_valid(d_avalid),
        .acc_ready(d_aready), .acc_out(d_out), .acc_count(d_count),
`ifdef CORDIC_ACC_SAT_EN
        .acc_sat(d_sat),
`endif
        .acc_len_err(d_err)
    );

`ifndef CORDIC_ACC_SAT_EN
    assign acc_sat = 1'b0;
    assign d_sat   = 1'b0;
`endif

    // Exact multiplier: product after lat cycles, done held high for 2 cycles.
    always @(posedge clk) begin
        if (mul_start) begin
            start_cnt <= start_cnt + 1;
            prod      <= $signed(mul_x) * $signed(mul_z);
            cd        <= lat;
            hold      <= 0;
            mul_done  <= 1'b0;
        end else if (cd > 0) begin
            if (cd == 1) begin
                mul_done <= 1'b1;
                mul_y    <= prod;
                hold     <= 2;
            end
            cd <= cd - 1;
        end else if (hold > 0) begin
            if (hold == 1) mul_done <= 1'b0;
            hold <= hold - 1;
        end
    end

    task automatic send_pair(input int x, input int z, input logic last);
        int n;
        in_x = 8'(x); in_z = 8'(z); in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_pair_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!acc_valid && n < 400) begin @(posedge clk); #1; n++; end
        if (!acc_valid) begin
            n_cmp++; n_err++;
            $display("FAIL %s acc_valid_timeout got=%b required 1", tag, acc_valid);
        end
    endtask

    task automatic handshake();
        acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, mul_start, acc_valid, acc_len_err} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags got=%b required 0000",
                     {in_ready, mul_start, acc_valid, acc_len_err});
        end
        n_cmp++;
        if (acc_out !== 24'd0 || acc_count !== 9'd0 || mul_x !== 8'd0 || mul_z !== 8'd0) begin
            n_err++;
            $display("FAIL reset_data acc=%0d cnt=%0d x=%0d z=%0d required 0",
                     acc_out, acc_count, mul_x, mul_z);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready got=%b required 1", in_ready);
        end
    endtask

    task automatic test_three_pairs();
        int s0;
        lat = 5;
        s0 = start_cnt;
        send_pair(3, 4, 1'b0);
        send_pair(-5, 6, 1'b0);
        send_pair(7, -8, 1'b1);
        wait_out("three");
        n_cmp++;
        if ($signed(acc_out) !== -74) begin
            n_err++; $display("FAIL three_sum got=%0d required -74", $signed(acc_out));
        end
        n_cmp++;
        if (acc_count !== 9'd3 || acc_len_err !== 1'b0) begin
            n_err++;
            $display("FAIL three_cnt got=%0d/%b required 3/0", acc_count, acc_len_err);
        end
        n_cmp++;
        if (start_cnt - s0 !== 3) begin
            n_err++; $display("FAIL three_starts got=%0d required 3", start_cnt - s0);
        end
        handshake();
        n_cmp++;
        if (acc_valid !== 1'b0 || acc_count !== 9'd0) begin
            n_err++;
            $display("FAIL three_clear got=%b/%0d required 0/0", acc_valid, acc_count);
        end
    endtask

    task automatic test_single();
        int  n;
        logic bad;
        lat = 1;
        send_pair(-128, -128, 1'b1);
        bad = 1'b0;
        n = 0;
        while (!acc_valid && n < 100) begin
            if (in_ready) bad = 1'b1;
            @(posedge clk); #1; n++;
        end
        if (in_ready) bad = 1'b1;
        n_cmp++;
        if (bad !== 1'b0 || acc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready_low got=%b/%b required 0/1", bad, acc_valid);
        end
        n_cmp++;
        if ($signed(acc_out) !== 16384 || acc_count !== 9'd1) begin
            n_err++;
            $display("FAIL single_sum got=%0d/%0d required 16384/1",
                     $signed(acc_out), acc_count);
        end
        handshake();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL single_ready_after got=%b required 1", in_ready);
        end
    endtask

    task automatic test_max_len();
        lat = 1;
        for (int i = 0; i < 256; i++) send_pair(127, 127, 1'b0);
        wait_out("maxlen");
        n_cmp++;
        if ($signed(acc_out) !== 4129024) begin
            n_err++; $display("FAIL maxlen_sum got=%0d required 4129024", $signed(acc_out));
        end
        n_cmp++;
        if (acc_count !== 9'd256 || acc_len_err !== 1'b1) begin
            n_err++;
            $display("FAIL maxlen_cnt got=%0d/%b required 256/1", acc_count, acc_len_err);
        end
        handshake();
        n_cmp++;
        if (acc_len_err !== 1'b0) begin
            n_err++; $display("FAIL maxlen_err_clear got=%b required 0", acc_len_err);
        end
    endtask

    task automatic test_back_to_back();
        logic bad;
        lat = 2;
        send_pair(1, 1, 1'b1);
        wait_out("bp");
        // Offer a pair while the result is stalled; it must not be taken.
        in_valid = 1'b1; in_x = 8'd5; in_z = 8'd5; in_last = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (acc_valid !== 1'b1 || $signed(acc_out) !== 1 || acc_count !== 9'd1 ||
                in_ready !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++; $display("FAIL bp_stable got=%b required 0", bad);
        end
        handshake();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++;
        if (acc_count !== 9'd0 || acc_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_clear got=%0d/%b/%b required 0/0/1", acc_count, acc_valid,
                     in_ready);
        end
        send_pair(2, 2, 1'b1);
        wait_out("bp2");
        n_cmp++;
        if ($signed(acc_out) !== 4 || acc_count !== 9'd1) begin
            n_err++;
            $display("FAIL bp_next got=%0d/%0d required 4/1", $signed(acc_out), acc_count);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        lat = 3;
        send_pair(9, 9, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        n_cmp++;
        if (acc_out !== 24'd0 || acc_count !== 9'd0 || acc_valid !== 1'b0 ||
            in_ready !== 1'b1 || mul_x !== 8'd0) begin
            n_err++;
            $display("FAIL rstmid_state acc=%0d cnt=%0d v=%b r=%b x=%0d required 0/0/0/1/0",
                     acc_out, acc_count, acc_valid, in_ready, mul_x);
        end
        lat = 1;
        send_pair(1, 1, 1'b1);
        wait_out("rstmid");
        n_cmp++;
        if ($signed(acc_out) !== 1 || acc_count !== 9'd1) begin
            n_err++;
            $display("FAIL rstmid_next got=%0d/%0d required 1/1", $signed(acc_out), acc_count);
        end
        handshake();
    endtask

    task automatic feed16(input int x, input int z, input logic last);
        int n;
        d_x = 8'(x); d_z = 8'(z); d_last = last; d_valid = 1'b1;
        n = 0;
        while (!d_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        d_valid = 1'b0; d_last = 1'b0;
        n = 0;
        while (!d_start && n < 100) begin @(posedge clk); #1; n++; end
        if (!d_start) begin
            n_cmp++; n_err++;
            $display("FAIL w16_start_timeout got=%b required 1", d_start);
        end
        @(posedge clk); #1;
        d_my = 16'(x * z);
        d_done = 1'b1;
        @(posedge clk); #1;
        d_done = 1'b0;
    endtask

    task automatic test_width16();
        int n;
        int exp_sum;
        feed16(127, 127, 1'b0);
        feed16(127, 127, 1'b0);
        feed16(127, 127, 1'b1);
        n = 0;
        while (!d_avalid && n < 100) begin @(posedge clk); #1; n++; end
`ifdef CORDIC_ACC_SAT_EN
        exp_sum = 32767;
`else
        exp_sum = -17149;
`endif
        n_cmp++;
        if ($signed(d_out) !== exp_sum || d_count !== 9'd3 || d_avalid !== 1'b1) begin
            n_err++;
            $display("FAIL w16_sum got=%0d/%0d/%b required %0d/3/1", $signed(d_out), d_count,
                     d_avalid, exp_sum);
        end
`ifdef CORDIC_ACC_SAT_EN
        n_cmp++;
        if (d_sat !== 1'b1) begin
            n_err++; $display("FAIL w16_sat got=%b required 1", d_sat);
        end
`endif
        d_aready = 1'b1;
        @(posedge clk); #1;
        d_aready = 1'b0;
        n_cmp++;
        if (d_out !== 16'd0 || d_sat !== 1'b0 || d_avalid !== 1'b0) begin
            n_err++;
            $display("FAIL w16_clear got=%0d/%b/%b required 0/0/0", d_out, d_sat, d_avalid);
        end
    endtask

    initial begin
        test_reset();
        test_three_pairs();
        test_single();
        test_max_len();
        test_back_to_back();
        test_reset_mid();
        test_width16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
